digit_match_sequencer: RTL and testbench
========================================

// Module: digit_match_sequencer
// PURPOSE
//  Sequences the 11x11 digit classifier: streams the captured image once per
//  template through a single time-shared pixel difference unit and
//  accumulates a per-template score. It then reports the digit (0..9) with the
//  lowest score. It replaces ten parallel 121-instance difference arrays with
//  one unit plus a counter/FSM. It sits between the image buffer and the
//  display/game logic.
// PARAMETERS
//  N         11  image side in pixels; the image has N*N = 121 pixels
//  NUM_TMPL  10  number of digit templates, indices 0..NUM_TMPL-1
//  PIX_W     8   pixel width, unsigned
//  ACC_W     24  score accumulator width; a score that would exceed the
//                accumulator saturates at all-ones
// PORTS
//  clk         in   1      single clock; all logic is in this domain
//  reset       in   1      synchronous, active-high
//  start       in   1      request a classification; sampled only in IDLE
//  pix_rd      out  1      image read strobe
//  pix_addr    out  7      image read address = row*N + col, range 0..120
//  pix_data    in   PIX_W  image pixel; valid exactly 1 cycle after pix_rd
//  busy        out  1      high from the cycle after start is accepted until DONE
//  done        out  1      one-cycle pulse when the result is updated
//  digit       out  4      winning template index
//  best_score  out  ACC_W  score of the winning template
// BEHAVIOUR
//  - Reset: the FSM goes to IDLE. pix_rd, pix_addr, busy, done, digit and
//    best_score are all 0. All counters and accumulators clear.
//  - FSM states: IDLE -> RUN -> DRAIN -> CMP.
//    - From CMP: go to RUN if t < NUM_TMPL-1, otherwise go to DONE.
//    - DONE -> IDLE.
//  - IDLE: start=1 clears acc, t and p, sets best to all-ones, and enters RUN.
//    While busy, start is ignored.
//  - RUN (121 cycles): pix_rd=1, pix_addr=p, with p counting 0..120.
//    - In each cycle except the first, acc += diff(pixel p-1, template t pixel p-1).
//    - After p=120 the FSM goes to DRAIN.
//  - DRAIN (1 cycle): pix_rd=0; the pixel 120 term is accumulated.
//  - CMP (1 cycle): if acc < best (strict), then best<=acc and win<=t.
//    Ties therefore keep the lower index. Then acc<=0, p<=0, t<=t+1.
//  - Each template takes 123 cycles.
//    - Start accepted at cycle 0 => template t's CMP occurs at cycle 123*(t+1).
//    - DONE occurs at cycle 1231.
//  - DONE (1 cycle): done=1; digit<=win and best_score<=best.
//    digit and best_score hold until the next DONE, across IDLE.
//  - diff = |pix - tmpl|, PIX_W bits. acc adds diff zero-extended to ACC_W and
//    saturates at 2^ACC_W-1.
//  - Reset asserted mid-operation aborts the run. No done pulse is produced and
//    outputs return to their reset values.
// CONFIGURATION
//  - SQUARED_DIFF_EN defined: the accumulated term is diff*diff
//    (2*PIX_W bits), giving Euclidean distance squared. Maximum score is
//    121*65025 = 7,868,025, which fits in 24 bits.
//  - SQUARED_DIFF_EN undefined: the accumulated term is diff (sum of absolute
//    differences). Maximum score is 30,855.
//  - Timing and the FSM are identical in both modes.
// STRUCTURE
//  - Package digit_tmpl_pkg holds:
//    - constants N, NUM_PIX=121, NUM_TMPL
//    - state enum typedef
//    - function tmpl_pixel(digit, idx) returning the 8-bit template ROM value
//  - Sub-module pixel_diff_unit is combinational: (pix, tmpl) -> term.
//    The SQUARED_DIFF_EN switch lives inside it.
//  - The top level holds the FSM, the p/t counters, the accumulator, and the
//    best/win registers.
// TESTING
//  1. Image = template 3 exactly, start pulse -> done at cycle 1231,
//     digit=3, best_score=0, busy high for cycles 1..1230.
//  2. Same image with pixel [5][5] raised by 4 -> digit=3; best_score=4
//     (macro off) or 16 (SQUARED_DIFF_EN).
//  3. Address trace -> pix_rd high for exactly 1210 cycles, pix_addr runs
//     0..120 ten times, and pix_rd=0 in every DRAIN and CMP cycle.
//  4. start re-pulsed at cycles 10 and 600 -> ignored: a single done at 1231
//     with an unchanged result.
//  5. reset at cycle 500 -> the next cycle has busy=0, digit=0, best_score=0,
//     and no done; a new start then gives done 1231 cycles later.
//  6. Image = all 255 with NUM_TMPL overridden to 2 (identical templates)
//     -> tie, so digit=0 at cycle 247.

Source files
------------

// File: rtl/digit_match_sequencer_pkg.sv
// digit_tmpl_pkg: shared constants, FSM state type and the digit template ROM.
package digit_tmpl_pkg;
    localparam int N        = 11;
    localparam int NUM_PIX  = N * N;
    localparam int NUM_TMPL = 10;
    localparam int PIX_W    = 8;
    localparam int ACC_W    = 24;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} state_t;

    // Every template holds the same ramp of values, cyclically shifted by 12 pixels per digit.
    function automatic logic [PIX_W-1:0] tmpl_pixel(input logic [3:0] digit, input logic [6:0] idx);
        logic [8:0] s;
        s = 9'(idx) + 9'(digit) * 9'd12;
        s = s >= 9'(NUM_PIX) ? s - 9'(NUM_PIX) : s;
        return {s[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/digit_match_sequencer_if.sv
// digit_match_sequencer_if: start/result handshake and image-buffer read port of the sequencer.
interface digit_match_sequencer_if;
    import digit_tmpl_pkg::*;
    logic             start;
    logic             pix_rd;
    logic [6:0]       pix_addr;
    logic [PIX_W-1:0] pix_data;
    logic             busy;
    logic             done;
    logic [3:0]       digit;
    logic [ACC_W-1:0] best_score;

    modport master (output start, pix_data, input pix_rd, pix_addr, busy, done, digit, best_score);
    modport slave  (input start, pix_data, output pix_rd, pix_addr, busy, done, digit, best_score);
endinterface

// File: rtl/digit_match_sequencer_pixel_diff_unit.sv
// pixel_diff_unit: combinational |pix - tmpl| term; squared when SQUARED_DIFF_EN is defined.
module pixel_diff_unit
    import digit_tmpl_pkg::*;
(
    input  logic [PIX_W-1:0]   pix,
    input  logic [PIX_W-1:0]   tmpl,
    output logic [2*PIX_W-1:0] term
);
    logic [PIX_W-1:0]   diff;
    logic [2*PIX_W-1:0] ext;

    always_comb begin
        diff = pix > tmpl ? pix - tmpl : tmpl - pix;
        ext  = {{PIX_W{1'b0}}, diff};
`ifdef SQUARED_DIFF_EN
        term = ext * ext;
`else
        term = ext;
`endif
    end
endmodule

// File: rtl/digit_match_sequencer.sv
// digit_match_sequencer: streams the image once per template through one diff unit, reports the lowest-score digit.
// Build option SQUARED_DIFF_EN (in pixel_diff_unit) switches the score from SAD to squared distance.
module digit_match_sequencer
    import digit_tmpl_pkg::*;
#(
    parameter int NUM_TMPL = digit_tmpl_pkg::NUM_TMPL
) (
    input logic                    clk,
    input logic                    reset,
    digit_match_sequencer_if.slave io
);
    state_t             state, nxt;
    logic [6:0]         p, pp;
    logic [3:0]         t, win, digit_q;
    logic [ACC_W-1:0]   acc, best, score_q, acc_sat;
    logic [ACC_W:0]     sum;
    logic [2*PIX_W-1:0] term;
    logic [PIX_W-1:0]   tmpl_px;
    logic               acc_en, last_pix, last_t, better;

    pixel_diff_unit u_diff (.pix(io.pix_data), .tmpl(tmpl_px), .term(term));

    always_comb begin
        last_pix = p == 7'(NUM_PIX - 1);
        last_t   = t == 4'(NUM_TMPL - 1);
        better   = acc < best;
        tmpl_px  = tmpl_pixel(t, pp);
        sum      = {1'b0, acc} + (ACC_W + 1)'(term);
        acc_sat  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        nxt      = state;
        case (state)
            IDLE:    nxt = io.start ? RUN : IDLE;
            RUN:     nxt = last_pix ? DRAIN : RUN;
            DRAIN:   nxt = CMP;
            CMP:     nxt = last_t ? DONE : RUN;
            default: nxt = IDLE;
        endcase
    end

    assign io.pix_rd     = state == RUN;
    assign io.pix_addr   = p;
    assign io.busy       = state == RUN || state == DRAIN || state == CMP;
    assign io.done       = state == DONE;
    assign io.digit      = digit_q;
    assign io.best_score = score_q;

    // Pixel data arrives one cycle after its read, so the term uses the delayed index pp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            p       <= '0;
            pp      <= '0;
            t       <= '0;
            win     <= '0;
            acc     <= '0;
            best    <= '0;
            acc_en  <= 1'b0;
            digit_q <= '0;
            score_q <= '0;
        end else begin
            state  <= nxt;
            acc_en <= state == RUN;
            pp     <= p;
            if (acc_en) acc <= acc_sat;
            case (state)
                IDLE: if (io.start) begin
                    acc  <= '0;
                    t    <= '0;
                    p    <= '0;
                    win  <= '0;
                    best <= '1;
                end
                RUN: p <= last_pix ? '0 : p + 7'd1;
                CMP: begin
                    if (better) begin
                        best <= acc;
                        win  <= t;
                    end
                    acc <= '0;
                    p   <= '0;
                    t   <= t + 4'd1;
                    if (last_t) begin
                        digit_q <= better ? t : win;
                        score_q <= better ? acc : best;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_match_sequencer.sv
// tb_digit_match_sequencer: directed scoreboard bench for the template matcher, plus an address/busy trace monitor.
module tb_digit_match_sequencer;
    localparam int LAST = 1231;
`ifdef SQUARED_DIFF_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    typedef struct {
        int dg;
        int sc;
        int cy;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         cyc   = 0;
    int         total = 0;
    int         pass  = 0;
    int         done_a = 0;
    int         done_b = 0;
    int         t0_a  = -100000;
    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] img_a [121];
    logic [7:0] img_b [121];

    digit_match_sequencer_if a ();
    digit_match_sequencer_if b ();

    digit_match_sequencer dut_a (.clk(clk), .reset(reset), .io(a));
    digit_match_sequencer #(.NUM_TMPL(2)) dut_b (.clk(clk), .reset(reset), .io(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Image buffers: data valid one cycle after the read strobe.
    always @(posedge clk) if (a.pix_rd) a.pix_data <= img_a[a.pix_addr];
    always @(posedge clk) if (b.pix_rd) b.pix_data <= img_b[b.pix_addr];

    function automatic logic [7:0] tm(input int d, input int i);
        return 8'(2 * ((i + 12 * d) % 121));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load_tmpl(input int d);
        for (int i = 0; i < 121; i++) img_a[i] = tm(d, i);
    endtask

    task automatic start_a(input int dg, input int sc);
        @(negedge clk);
        a.start = 1'b1;
        t0_a = cyc;
        qa.push_back('{dg, sc, cyc + LAST});
        @(negedge clk);
        a.start = 1'b0;
    endtask

    task automatic pulse_a(input int k);
        while (cyc < t0_a + k) @(negedge clk);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
    endtask

    task automatic run_a(input int dg, input int sc, input bit retrig);
        int n0;
        n0 = done_a;
        start_a(dg, sc);
        if (retrig) begin
            pulse_a(10);
            pulse_a(600);
        end
        for (int i = 0; i < 1400 && done_a == n0; i++) @(negedge clk);
        chk("done_a_seen", done_a - n0, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (a.done) begin
                chk("done_a_expected", qa.size(), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("digit_a", a.digit, e.dg);
                    chk("score_a", a.best_score, e.sc);
                    chk("done_a_cycle", cyc, e.cy);
                end
                done_a++;
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (b.done) begin
                chk("done_b_expected", qb.size(), 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("digit_b", b.digit, e.dg);
                    chk("score_b", b.best_score, e.sc);
                    chk("done_b_cycle", cyc, e.cy);
                end
                done_b++;
            end
        end
    end

    // Cycle k after acceptance: RUN for (k-1)%123 < 121, then DRAIN and CMP, DONE at k=1231.
    initial begin : trace_a
        int k, err, rd;
        bit er;
        err = 0;
        rd  = 0;
        forever begin
            @(negedge clk);
            k = cyc - t0_a;
            if (k >= 1 && k <= LAST) begin
                if (k == 1) begin
                    err = 0;
                    rd  = 0;
                end
                er = (k < LAST) && ((k - 1) % 123 < 121);
                if (a.pix_rd != er) err++;
                if (er && a.pix_addr != 7'((k - 1) % 123)) err++;
                if (a.busy != (k < LAST)) err++;
                if (a.done != (k == LAST)) err++;
                rd += int'(a.pix_rd);
                if (k == LAST) begin
                    chk("trace_a_errors", err, 0);
                    chk("rd_cycles_a", rd, 1210);
                end
            end
        end
    end

    initial begin
        int n0;
        a.start = 1'b0;
        b.start = 1'b0;
        for (int i = 0; i < 121; i++) img_b[i] = 8'hFF;
        load_tmpl(3);
        repeat (3) @(negedge clk);
        chk("rst_pix_rd", a.pix_rd, 0);
        chk("rst_pix_addr", a.pix_addr, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_done", a.done, 0);
        chk("rst_digit", a.digit, 0);
        chk("rst_score", a.best_score, 0);
        chk("rst_b_busy", b.busy, 0);
        reset = 1'b0;

        run_a(3, 0, 1'b0);
        img_a[60] = img_a[60] + 8'd4;
        run_a(3, SQ ? 16 : 4, 1'b0);
        run_a(3, SQ ? 16 : 4, 1'b1);

        load_tmpl(7);
        start_a(7, 0);
        while (cyc < t0_a + 500) @(negedge clk);
        reset = 1'b1;
        qa.delete();
        t0_a = -100000;
        @(negedge clk);
        chk("abort_busy", a.busy, 0);
        chk("abort_digit", a.digit, 0);
        chk("abort_score", a.best_score, 0);
        chk("abort_done", a.done, 0);
        chk("abort_pix_rd", a.pix_rd, 0);
        reset = 1'b0;
        run_a(7, 0, 1'b0);

        load_tmpl(9);
        img_a[0] = img_a[0] - 8'd10;
        run_a(9, SQ ? 100 : 10, 1'b0);

        n0 = done_b;
        @(negedge clk);
        b.start = 1'b1;
        qb.push_back('{0, SQ ? 2795705 : 16335, cyc + 247});
        @(negedge clk);
        b.start = 1'b0;
        for (int i = 0; i < 400 && done_b == n0; i++) @(negedge clk);
        chk("done_b_seen", done_b - n0, 1);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
